// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, 9-bit shift on device clock, ACK, timeouts.
// Optional build macro PS2TX_ACK_CHECK_EN: a missing device ACK also raises err alongside done.
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYC  = 2500,
    parameter int unsigned START_TO_CYC = 375000,
    parameter int unsigned XFER_TO_CYC  = 50000
) (
    input  logic       clk25,
    input  logic       reset_n,
    input  logic       ps2_clk_i,
    input  logic       ps2_dat_i,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    input  logic [7:0] tx_data,
    input  logic       tx_stb,
    output logic       busy,
    output logic       done,
    output logic       err
);

    typedef enum logic [2:0] {
        S_IDLE, S_INHIBIT, S_START, S_RTS, S_SHIFT, S_ACK, S_WAITIDLE
    } state_e;

    localparam logic [18:0] INH_LAST   = 19'(INHIBIT_CYC - 1);
    localparam logic [18:0] START_LAST = 19'(START_TO_CYC - 1);
    localparam logic [18:0] XFER_LAST  = 19'(XFER_TO_CYC - 1);

`ifdef PS2TX_ACK_CHECK_EN
    localparam logic ACK_CHECK = 1'b1;
`else
    localparam logic ACK_CHECK = 1'b0;
`endif

    state_e      state_q, state_d;
    logic [8:0]  shift_q, shift_d;
    logic [3:0]  edge_q, edge_d;
    logic [18:0] cnt_q, cnt_d;
    logic        ack_bad_q, ack_bad_d;
    logic        clk_oe_q, clk_oe_d;
    logic        dat_oe_q, dat_oe_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        timeout;

    logic clk_s1_q, clk_s2_q, clk_prev_q, fall_q;
    logic dat_s1_q, dat_s2_q;

    // NOTE: synchroniser flops reset to 1 (idle bus level) so leaving reset never fakes a falling edge.
    always_ff @(posedge clk25 or negedge reset_n) begin
        if (!reset_n) begin
            clk_s1_q   <= 1'b1;
            clk_s2_q   <= 1'b1;
            clk_prev_q <= 1'b1;
            fall_q     <= 1'b0;
            dat_s1_q   <= 1'b1;
            dat_s2_q   <= 1'b1;
        end else begin
            clk_s1_q   <= ps2_clk_i;
            clk_s2_q   <= clk_s1_q;
            clk_prev_q <= clk_s2_q;
            fall_q     <= clk_prev_q & ~clk_s2_q;
            dat_s1_q   <= ps2_dat_i;
            dat_s2_q   <= dat_s1_q;
        end
    end

    // NOTE: every variable gets a default at the top of always_comb, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        edge_d    = edge_q;
        cnt_d     = cnt_q;
        ack_bad_d = ack_bad_q;
        dat_oe_d  = dat_oe_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        timeout   = 1'b0;

        case (state_q)
            S_IDLE: begin
                // A request in the done cycle is dropped; one cycle later it is accepted.
                if (tx_stb && !done_q) begin
                    shift_d   = {~^tx_data, tx_data};
                    cnt_d     = '0;
                    edge_d    = '0;
                    ack_bad_d = 1'b0;
                    state_d   = S_INHIBIT;
                end
            end
            S_INHIBIT: begin
                cnt_d = cnt_q + 19'd1;
                if (cnt_q == INH_LAST) state_d = S_START;
            end
            S_START: begin
                cnt_d   = '0;
                state_d = S_RTS;
            end
            S_RTS: begin
                cnt_d = cnt_q + 19'd1;
                if (cnt_q == START_LAST) begin
                    timeout = 1'b1;
                end else if (fall_q) begin
                    edge_d   = 4'd1;
                    cnt_d    = 19'd1;
                    dat_oe_d = ~shift_q[0];
                    shift_d  = {1'b0, shift_q[8:1]};
                    state_d  = S_SHIFT;
                end
            end
            S_SHIFT: begin
                cnt_d = cnt_q + 19'd1;
                if (cnt_q == XFER_LAST) begin
                    timeout = 1'b1;
                end else if (fall_q) begin
                    edge_d = edge_q + 4'd1;
                    if (edge_q == 4'd9) begin
                        dat_oe_d = 1'b0;
                        state_d  = S_ACK;
                    end else begin
                        dat_oe_d = ~shift_q[0];
                        shift_d  = {1'b0, shift_q[8:1]};
                    end
                end
            end
            S_ACK: begin
                cnt_d = cnt_q + 19'd1;
                if (cnt_q == XFER_LAST) begin
                    timeout = 1'b1;
                end else if (fall_q) begin
                    edge_d    = edge_q + 4'd1;
                    ack_bad_d = dat_s2_q;
                    state_d   = S_WAITIDLE;
                end
            end
            S_WAITIDLE: begin
                cnt_d = cnt_q + 19'd1;
                if (cnt_q == XFER_LAST) begin
                    timeout = 1'b1;
                end else if (clk_s2_q && dat_s2_q) begin
                    done_d  = 1'b1;
                    err_d   = ACK_CHECK & ack_bad_q;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (timeout) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
            err_d   = 1'b1;
        end

        // Pad controls are registered from the next state so they change with the state itself.
        clk_oe_d = (state_d == S_INHIBIT) || (state_d == S_START);
        busy_d   = (state_d != S_IDLE);
        if (state_d == S_START || state_d == S_RTS)
            dat_oe_d = 1'b1;
        else if (state_d == S_IDLE || state_d == S_INHIBIT)
            dat_oe_d = 1'b0;
    end

    always_ff @(posedge clk25 or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            shift_q   <= '0;
            edge_q    <= '0;
            cnt_q     <= '0;
            ack_bad_q <= 1'b0;
            clk_oe_q  <= 1'b0;
            dat_oe_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            edge_q    <= edge_d;
            cnt_q     <= cnt_d;
            ack_bad_q <= ack_bad_d;
            clk_oe_q  <= clk_oe_d;
            dat_oe_q  <= dat_oe_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign ps2_clk_oe = clk_oe_q;
    assign ps2_dat_oe = dat_oe_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain bus, PS/2 device model, scoreboard checked on every done pulse.
// Timeouts and device clock are scaled down to keep the run short.
module tb_ps2_host_tx;

    localparam int INH  = 250;
    localparam int STO  = 6000;
    localparam int XTO  = 5000;
    localparam int HP   = 100;   // device clock half period in clk25 cycles

`ifdef PS2TX_ACK_CHECK_EN
    localparam logic ACK_ERR = 1'b1;
`else
    localparam logic ACK_ERR = 1'b0;
`endif

    typedef struct {
        logic        err;
        logic        chk;
        logic [10:0] frame;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       ps2_clk_oe, ps2_dat_oe;
    logic [7:0] tx_data = 8'h00;
    logic       tx_stb = 1'b0;
    logic       busy, done, err;
    logic       dev_clk_low = 1'b0;
    logic       dev_dat_low = 1'b0;
    logic       ps2_clk_i, ps2_dat_i;

    exp_t        sb[$];
    exp_t        e;
    logic [10:0] frame;
    int          n_cmp = 0;
    int          n_mis = 0;
    int          done_cnt = 0;
    int          cyc = 0;
    int          first_fall_cyc = 0;
    int          last_done_cyc = 0;

    assign ps2_clk_i = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_dat_i = ~(ps2_dat_oe | dev_dat_low);

    ps2_host_tx #(.INHIBIT_CYC(INH), .START_TO_CYC(STO), .XFER_TO_CYC(XTO)) dut (
        .clk25(clk), .reset_n(reset_n),
        .ps2_clk_i(ps2_clk_i), .ps2_dat_i(ps2_dat_i),
        .ps2_clk_oe(ps2_clk_oe), .ps2_dat_oe(ps2_dat_oe),
        .tx_data(tx_data), .tx_stb(tx_stb),
        .busy(busy), .done(done), .err(err)
    );

    always #20 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: each done pulse pops one expectation.
    always begin
        @(posedge clk);
        #1;
        if (done === 1'b1) begin
            done_cnt++;
            last_done_cyc = cyc;
            if (sb.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("err_at_done", 32'(err), 32'(e.err));
                check("busy_at_done", 32'(busy), 32'd0);
                check("oe_at_done", {30'd0, ps2_clk_oe, ps2_dat_oe}, 32'd0);
                if (e.chk) check("frame", 32'(frame), 32'(e.frame));
            end
        end
    end

    task automatic push(input logic er, input logic ck, input logic [10:0] fr);
        exp_t x;
        x.err = er; x.chk = ck; x.frame = fr;
        sb.push_back(x);
    endtask

    task automatic send(input logic [7:0] d);
        @(negedge clk);
        tx_data = d;
        tx_stb  = 1'b1;
        @(negedge clk);
        tx_stb  = 1'b0;
        tx_data = 8'hA5;
    endtask

    // Device: waits for request-to-send, generates n_edges clocks, samples on rising edges.
    task automatic device(input int n_edges, input logic do_ack);
        int t = 0;
        frame = '1;
        while (!(ps2_clk_i && !ps2_dat_i) && t < 5000) begin
            @(negedge clk);
            t++;
        end
        check("dev_saw_rts", 32'(t < 5000), 32'd1);
        frame[0] = ps2_dat_i;
        for (int i = 0; i < n_edges; i++) begin
            repeat (HP) @(negedge clk);
            dev_clk_low = 1'b1;
            if (i == 0) first_fall_cyc = cyc;
            repeat (HP) @(negedge clk);
            dev_clk_low = 1'b0;
            if (i < 10) frame[i+1] = ps2_dat_i;
            if (i == 9 && do_ack) dev_dat_low = 1'b1;
            if (i == 10) dev_dat_low = 1'b0;
        end
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (done !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("done_within_budget", 32'(done === 1'b1), 32'd1);
    endtask

    initial begin
        #2000000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        int diff;

        // Reset state
        #50;
        check("rst_clk_oe", 32'(ps2_clk_oe), 32'd0);
        check("rst_dat_oe", 32'(ps2_dat_oe), 32'd0);
        check("rst_busy",   32'(busy), 32'd0);
        check("rst_done",   32'(done), 32'd0);
        check("rst_err",    32'(err), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);

        // 0xED with inhibit/start timing measured; parity 1
        push(1'b0, 1'b1, {1'b1, 1'b1, 8'hED, 1'b0});
        send(8'hED);
        fork
            begin
                check("busy_cycle1", 32'(busy), 32'd1);
                n = 0;
                while (ps2_clk_oe && !ps2_dat_oe && n < INH + 10) begin
                    n++;
                    @(negedge clk);
                end
                check("inhibit_len", 32'(n), 32'(INH));
                check("start_oe", {30'd0, ps2_clk_oe, ps2_dat_oe}, 32'd3);
                @(negedge clk);
                check("rts_oe", {30'd0, ps2_clk_oe, ps2_dat_oe}, 32'd1);
            end
            device(11, 1'b1);
        join
        wait_done(500);

        // 0x00 (parity 1); then a request in the done cycle is dropped and the next one taken
        push(1'b0, 1'b1, {1'b1, 1'b1, 8'h00, 1'b0});
        send(8'h00);
        device(11, 1'b1);
        wait_done(500);
        tx_data = 8'hFF;
        tx_stb  = 1'b1;
        @(negedge clk);
        check("busy_after_done_stb", 32'(busy), 32'd0);
        tx_data = 8'h01;
        @(negedge clk);
        tx_stb  = 1'b0;
        check("busy_after_accept", 32'(busy), 32'd1);
        push(1'b0, 1'b1, {1'b1, 1'b0, 8'h01, 1'b0});
        device(11, 1'b1);
        wait_done(500);

        // Withheld ACK on 0x0F (parity 1)
        push(ACK_ERR, 1'b1, {1'b1, 1'b1, 8'h0F, 1'b0});
        send(8'h0F);
        device(11, 1'b0);
        wait_done(500);

        // 0x5A (parity 1) with a 0xFF request mid-frame that must be ignored
        push(1'b0, 1'b1, {1'b1, 1'b1, 8'h5A, 1'b0});
        send(8'h5A);
        fork
            device(11, 1'b1);
            begin
                repeat (INH + HP * 8) @(negedge clk);
                tx_data = 8'hFF;
                tx_stb  = 1'b1;
                @(negedge clk);
                tx_stb  = 1'b0;
            end
        join
        wait_done(500);
        repeat (20) @(negedge clk);
        check("no_extra_done", 32'(done_cnt), 32'd5);

        // Device never clocks: start timeout exactly STO cycles after RTS
        push(1'b1, 1'b0, 11'd0);
        send(8'h3C);
        n = 0;
        while (!(ps2_clk_oe == 1'b0 && ps2_dat_oe == 1'b1) && n < INH + 10) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        while (done !== 1'b1 && n < STO + 100) begin
            @(negedge clk);
            n++;
        end
        check("start_timeout_len", 32'(n), 32'(STO));

        // Device stops after 5 edges: transfer timeout about XTO after the first edge
        push(1'b1, 1'b0, 11'd0);
        send(8'hA5);
        device(5, 1'b1);
        wait_done(XTO + 500);
        @(negedge clk);
        diff = last_done_cyc - first_fall_cyc;
        check("xfer_timeout_window", 32'(diff >= XTO && diff <= XTO + 5), 32'd1);

        // Reset mid-SHIFT releases lines at once, then 0xF4 (parity 0) completes
        send(8'h12);
        device(4, 1'b1);
        repeat (10) @(negedge clk);
        check("pre_reset_busy", 32'(busy), 32'd1);
        check("pre_reset_dat_oe", 32'(ps2_dat_oe), 32'd1);
        #5 reset_n = 1'b0;
        #1;
        check("async_rst_oe", {30'd0, ps2_clk_oe, ps2_dat_oe}, 32'd0);
        check("async_rst_busy", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        push(1'b0, 1'b1, {1'b1, 1'b0, 8'hF4, 1'b0});
        send(8'hF4);
        device(11, 1'b1);
        wait_done(500);

        repeat (20) @(negedge clk);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        check("done_count", 32'(done_cnt), 32'd8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device PS/2 transmitter: serialises one command byte (e.g. 0xED set-LEDs, 0xFF reset) from the BK side to the keyboard over the same PS2_CLK/PS2_DAT pair the keyboard receiver listens on. It performs the inhibit / request-to-send sequence, shifts data, odd parity and stop on device-generated clock edges, checks the device ACK and enforces protocol timeouts. It sits beside the keyboard receiver in the bk0010 core; the board top drives the open-drain pads from its `*_oe` outputs.

## Interface
- `INHIBIT_CYC`, 2500: clock-low inhibit length in `clk25` cycles (100 µs).
- `START_TO_CYC`, 375000: max cycles from request-to-send to the first device falling edge (15 ms).
- `XFER_TO_CYC`, 50000: max cycles from the first falling edge to the end of the ACK (2 ms).

- `clk25`  in  1  system clock, 25 MHz.
- `reset_n`  in  1  asynchronous, active-low reset.
- `ps2_clk_i`  in  1  raw PS2_CLK pad level (asynchronous).
- `ps2_dat_i`  in  1  raw PS2_DAT pad level (asynchronous).
- `ps2_clk_oe`  out  1  1 = pull PS2_CLK low; 0 = release.
- `ps2_dat_oe`  out  1  1 = pull PS2_DAT low; 0 = release.
- `tx_data`  in  8  byte to send; sampled when `tx_stb` is accepted.
- `tx_stb`  in  1  one-cycle send request.
- `busy`  out  1  transfer in progress; the keyboard receiver ignores the line while this is high.
- `done`  out  1  one-cycle pulse at the end of every accepted transfer.
- `err`  out  1  one-cycle pulse coincident with `done` on NACK or timeout.

## Operation
- Inputs are passed through a 2-FF synchroniser plus a history FF. A falling edge is `prev & ~cur`.
- Frame: start (0), D0..D7 LSB first, parity = `~^tx_data` (odd), stop (1, line released), ACK (0, driven by the device).
- Per-state behaviour:
  - IDLE: both `oe` = 0, `busy` = 0. When `tx_stb` is high, latch `{parity, tx_data}` into a 9-bit shifter, clear the counters and go to INHIBIT.
  - INHIBIT: `clk_oe` = 1 for `INHIBIT_CYC` cycles, then go to START.
  - START: lasts 1 cycle with `clk_oe` = 1 and `dat_oe` = 1 (data pulled low before the clock is released), then go to RTS.
  - RTS: `clk_oe` = 0, `dat_oe` = 1. On a falling edge, put bit D0 on the line and go to SHIFT.
  - SHIFT: on each falling edge, put the next shifter bit on the line (`dat_oe` = ~bit). After parity is on the line, the next falling edge releases data (stop bit) and moves to ACK.
  - ACK: on a falling edge, sample the synchronised data. Go to WAITIDLE.
  - WAITIDLE: wait until the synchronised clock and data are both high, then pulse `done` and return to IDLE.
- A 4-bit edge counter tracks the 11 device falling edges.
- A 19-bit timeout counter starts on entry to RTS.
  - If it reaches `START_TO_CYC` before the first edge, or reaches `XFER_TO_CYC` counted from the first edge without leaving WAITIDLE, the block releases both lines, pulses `done` + `err`, and returns to IDLE.
- `tx_stb` while `busy` = 1 is ignored; it is neither queued nor does it cause an error.
- `tx_data` is don't-care except in the accept cycle.

## Timing
- Reset values: `ps2_clk_oe` = 0, `ps2_dat_oe` = 0, `busy` = 0, `done` = 0, `err` = 0; state IDLE.
- Reset is asynchronous: asserting it mid-transfer releases both lines on the same clock edge, with no `done` pulse.
- Latency from `tx_stb` (cycle 0):
  - `busy` and `clk_oe` rise at cycle 1.
  - `dat_oe` rises at cycle 1+`INHIBIT_CYC`.
  - `clk_oe` falls at cycle 2+`INHIBIT_CYC`.
- Pad falling edge to data update: 4 cycles (2 sync + 1 edge + 1 output register), i.e. 160 ns, well inside the device's clock-low half period.
- In the `done` cycle, `busy` = 0 and the block is in IDLE. A `tx_stb` in the cycle after `done` is accepted; a `tx_stb` in the `done` cycle itself is ignored.
- A glitch shorter than 2 cycles on the clock pad may be missed.

## Configuration
- `PS2TX_ACK_CHECK_EN` defined: if the data sampled on the 11th falling edge is 1 (no ACK), `err` pulses with `done`.
- `PS2TX_ACK_CHECK_EN` not defined: the ACK level is not checked. `err` is produced by timeouts only.

## Test plan
- Bench device model clocks at 12.5 kHz, samples on rising edges, and ACKs. Send `tx_data` = 0xED → model receives bits 1,0,1,1,0,1,1,1, parity 1, stop 1; `done` = 1 and `err` = 0; `clk_oe` was high for exactly 2500 cycles.
- Send 0x00 → parity bit 1. Send 0x01 → parity bit 0. Both ACKed, no `err`.
- Model withholds the ACK (data stays high on edge 11) → with `PS2TX_ACK_CHECK_EN`, `done` and `err` pulse together; without it, `done` pulses alone.
- Model never clocks → at 375000 cycles after RTS, both `oe` = 0 and `done` + `err` pulse. Model stops after 5 edges → `err` 50000 cycles after the first edge.
- Second `tx_stb` mid-frame with 0xFF → ignored; the first byte completes unchanged and no extra `done` pulse occurs.
- `reset_n` low during SHIFT → both `oe` = 0 and `busy` = 0 immediately. After release, a new `tx_stb` of 0xF4 completes normally.
